// File: rtl/fp_div_pkg.sv
// Constants, result classes and the per-stage payload shared by the
// single-precision divider pipeline.
package fp_div_pkg;

  localparam int EXP_BIAS      = 127;
  localparam int MANT_W        = 23;
  localparam int QUOT_BITS     = 25;
  localparam int F_DIV_LATENCY = 27;
  localparam logic [31:0] CANON_NAN = 32'h7FC00000;

  typedef enum logic [1:0] {CLS_NORMAL, CLS_ZERO, CLS_INF, CLS_NAN} cls_t;

  typedef struct packed {
    logic                 sign;
    logic signed [9:0]    exp;
    cls_t                 cls;
    logic [MANT_W:0]      div;   // divisor significand incl. hidden 1
    logic [MANT_W+1:0]    rem;   // partial remainder, stored doubled
    logic [QUOT_BITS-1:0] quot;
  } stage_t;

  localparam stage_t STAGE_RST = '{sign: 1'b0, exp: 10'sd0, cls: CLS_ZERO,
                                   div: '0, rem: '0, quot: '0};

endpackage

// File: rtl/fp_div_stage.sv
// One registered restoring-division iteration: produces one quotient bit,
// sign/exponent/class ride along untouched.
module fp_div_stage
  import fp_div_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  stage_t d,
  output stage_t q
);

  logic [MANT_W+2:0] diff;
  stage_t            nxt;

  // The remainder is held pre-doubled, so the trial subtract is a plain
  // R - mb and the doubling for the next step is folded into the shift.
  always_comb begin
    nxt      = d;
    diff     = {1'b0, d.rem} - {2'b00, d.div};
    nxt.quot = {d.quot[QUOT_BITS-2:0], ~diff[MANT_W+2]};
    nxt.rem  = diff[MANT_W+2] ? (d.rem << 1) : (diff[MANT_W+1:0] << 1);
  end

  always_ff @(posedge clk) begin
    if (rst) q <= STAGE_RST;
    else     q <= nxt;
  end

endmodule

// File: rtl/f_div.sv
// Streaming binary32 divider: out0 = in0 / in1, one result per cycle,
// 27 register stages (unpack, 25 quotient bits, round/pack).
module f_div
  import fp_div_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              running,
  input  logic              run,
  input  logic [DATA_W-1:0] in0,
  input  logic [DATA_W-1:0] in1,
  (* versat_latency = 27 *)
  output logic [DATA_W-1:0] out0
);

  generate
    if (DATA_W != 32) begin : g_bad_width
      $error("f_div supports only DATA_W = 32");
    end
  endgenerate

  logic unused_run;
  assign unused_run = run;

  logic [7:0]      ea, eb;
  logic [MANT_W:0] ma, mb;
  logic            a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  stage_t          s0, s0_q;

  // Unpack; subnormals count as zero since only the exponent field is tested.
  always_comb begin
    ea     = in0[30:23];
    eb     = in1[30:23];
    ma     = {1'b1, in0[22:0]};
    mb     = {1'b1, in1[22:0]};
    a_zero = (ea == 8'd0);
    b_zero = (eb == 8'd0);
    a_inf  = (ea == 8'hFF) && (in0[22:0] == 23'd0);
    b_inf  = (eb == 8'hFF) && (in1[22:0] == 23'd0);
    a_nan  = (ea == 8'hFF) && (in0[22:0] != 23'd0);
    b_nan  = (eb == 8'hFF) && (in1[22:0] != 23'd0);

    s0      = STAGE_RST;
    s0.sign = in0[31] ^ in1[31];
    s0.div  = mb;
    s0.exp  = $signed({2'b00, ea}) - $signed({2'b00, eb}) + 10'(EXP_BIAS);
    if (ma < mb) begin
      s0.rem = {ma, 1'b0};
      s0.exp = s0.exp - 10'sd1;
    end else begin
      s0.rem = {1'b0, ma};
    end

    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      s0.cls  = CLS_NAN;
      s0.sign = 1'b0;
    end else if (a_inf || b_zero) begin
      s0.cls = CLS_INF;
    end else if (a_zero || b_inf) begin
      s0.cls = CLS_ZERO;
    end else begin
      s0.cls = CLS_NORMAL;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) s0_q <= STAGE_RST;
    else     s0_q <= s0;
  end

  stage_t pipe [0:QUOT_BITS-1];

  generate
    for (genvar i = 0; i < QUOT_BITS; i++) begin : g_stage
      if (i == 0) begin : g_first
        fp_div_stage u_stage (.clk(clk), .rst(rst), .d(s0_q), .q(pipe[i]));
      end else begin : g_rest
        fp_div_stage u_stage (.clk(clk), .rst(rst), .d(pipe[i-1]), .q(pipe[i]));
      end
    end
  endgenerate

  logic [MANT_W:0]   mant;
  logic              guard, sticky, round_up;
  logic [MANT_W+1:0] mant_rnd;
  logic signed [9:0] exp_rnd;
  logic [DATA_W-1:0] pack_res, out_q;

  always_comb begin
    mant     = pipe[QUOT_BITS-1].quot[QUOT_BITS-1:1];
    guard    = pipe[QUOT_BITS-1].quot[0];
    sticky   = |pipe[QUOT_BITS-1].rem;
    round_up = guard & (sticky | mant[0]);
    mant_rnd = {1'b0, mant} + {{(MANT_W+1){1'b0}}, round_up};
    // A carry out means the significand rounded up to 2.0.
    exp_rnd  = pipe[QUOT_BITS-1].exp + $signed({9'd0, mant_rnd[MANT_W+1]});

    pack_res = '0;
    case (pipe[QUOT_BITS-1].cls)
      CLS_NAN:  pack_res = CANON_NAN;
      CLS_INF:  pack_res = {pipe[QUOT_BITS-1].sign, 8'hFF, 23'd0};
      CLS_ZERO: pack_res = {pipe[QUOT_BITS-1].sign, 31'd0};
      default: begin
        if (exp_rnd >= 10'sd255)
          pack_res = {pipe[QUOT_BITS-1].sign, 8'hFF, 23'd0};
        else if (exp_rnd <= 10'sd0)
          pack_res = {pipe[QUOT_BITS-1].sign, 31'd0};
        else
          pack_res = {pipe[QUOT_BITS-1].sign, exp_rnd[7:0],
                      mant_rnd[MANT_W+1] ? mant_rnd[MANT_W:1] : mant_rnd[MANT_W-1:0]};
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) out_q <= '0;
    else     out_q <= pack_res;
  end

  assign out0 = running ? out_q : '0;

endmodule

// File: tb/tb_f_div.sv
// Scoreboard bench for f_div: stimulus pushes expected quotients, a monitor
// pops and compares them 27 cycles later against a real-arithmetic model.
module tb_f_div;

  localparam int LAT = 27;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        running = 1'b1;
  logic        run = 1'b0;
  logic [31:0] in0 = 32'd0;
  logic [31:0] in1 = 32'd0;
  logic [31:0] out0;

  f_div #(.DATA_W(32)) dut (
    .clk(clk), .rst(rst), .running(running), .run(run),
    .in0(in0), .in1(in1), .out0(out0)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          issue;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  function automatic real mag(input logic [31:0] x);
    logic [10:0] e;
    e = {3'b000, x[30:23]} + 11'd896;
    return $bitstoreal({1'b0, e, x[22:0], 29'd0});
  endfunction

  // IEEE division in double, then round-to-nearest-even to 24 bits with
  // flush-to-zero and overflow-to-infinity.
  function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    logic        s, an, bn, ai, bi, az, bz;
    real         q;
    logic [63:0] bits;
    int          e;
    logic [24:0] m;
    logic [7:0]  eb;
    s  = a[31] ^ b[31];
    az = (a[30:23] == 8'd0);
    bz = (b[30:23] == 8'd0);
    ai = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    bi = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    an = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    bn = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    if (an || bn || (az && bz) || (ai && bi)) return 32'h7FC00000;
    if (ai || bz) return {s, 8'hFF, 23'd0};
    if (az || bi) return {s, 31'd0};
    q    = mag(a) / mag(b);
    bits = $realtobits(q);
    e    = int'(bits[62:52]) - 1023 + 127;
    m    = {2'b01, bits[51:29]};
    if (bits[28] && ((|bits[27:0]) || bits[29])) m = m + 25'd1;
    if (m[24]) begin
      m = m >> 1;
      e = e + 1;
    end
    if (e >= 255) return {s, 8'hFF, 23'd0};
    if (e <= 0) return {s, 31'd0};
    eb = 8'(e);
    return {s, eb, m[22:0]};
  endfunction

  function automatic logic [31:0] rand_normal(input bit wide);
    logic [7:0]  e;
    logic [22:0] f;
    logic        s;
    e = wide ? 8'($urandom_range(1, 254)) : 8'($urandom_range(100, 154));
    f = 23'($urandom_range(0, 32'h7FFFFF));
    s = 1'($urandom_range(0, 1));
    return {s, e, f};
  endfunction

  // One cycle of stimulus; a reset step voids everything still in flight.
  task automatic step(input logic r, input logic rn, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] expv);
    @(posedge clk);
    #1;
    rst     = r;
    running = rn;
    in0     = a;
    in1     = b;
    if (r) begin
      for (int i = 0; i < sb.size(); i++)
        if (sb[i].issue > cyc - LAT) sb[i].val = 32'd0;
      sb.push_back('{cyc, 32'd0});
    end else begin
      sb.push_back('{cyc, expv});
    end
  endtask

  task automatic rstep(input logic rn, input logic [31:0] a, input logic [31:0] b);
    step(1'b0, rn, a, b, ref_div(a, b));
  endtask

  initial begin
    exp_t        e;
    logic [31:0] want;
    forever begin
      @(posedge clk);
      #2;
      while (sb.size() > 0 && sb[0].issue + LAT < cyc) begin
        e = sb.pop_front();
        miscompares++;
        $display("FAIL sb_skipped issue=%0d: no check made, expected %h", e.issue, e.val);
      end
      if (sb.size() > 0 && sb[0].issue + LAT == cyc) begin
        e    = sb.pop_front();
        want = running ? e.val : 32'd0;
        vectors++;
        if (out0 !== want) begin
          miscompares++;
          $display("FAIL sb issue=%0d cyc=%0d: out0=%h expected=%h", e.issue, cyc, out0, want);
        end
      end
    end
  end

  initial begin
    repeat (3) step(1'b1, 1'b1, 32'd0, 32'd0, 32'd0);
    #1;
    vectors++;
    if (out0 !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_out: out0=%h expected=00000000", out0);
    end

    // Directed values, back to back
    step(1'b0, 1'b1, 32'h40C00000, 32'h40000000, 32'h40400000);
    step(1'b0, 1'b1, 32'h3F800000, 32'h40400000, 32'h3EAAAAAB);
    step(1'b0, 1'b1, 32'h3F800000, 32'h3F800000, 32'h3F800000);
    step(1'b0, 1'b1, 32'h3F800000, 32'h00000000, 32'h7F800000);
    step(1'b0, 1'b1, 32'hBF800000, 32'h00000000, 32'hFF800000);
    step(1'b0, 1'b1, 32'h00000000, 32'h00000000, 32'h7FC00000);
    step(1'b0, 1'b1, 32'h7FC12345, 32'h40000000, 32'h7FC00000);
    step(1'b0, 1'b1, 32'h80000000, 32'h40400000, 32'h80000000);
    step(1'b0, 1'b1, 32'h7F000000, 32'h3E800000, 32'h7F800000);
    step(1'b0, 1'b1, 32'h00800000, 32'h40000000, 32'h00000000);
    step(1'b0, 1'b1, 32'h7F800000, 32'hC0000000, 32'hFF800000);
    step(1'b0, 1'b1, 32'h40000000, 32'hFF800000, 32'h80000000);
    step(1'b0, 1'b1, 32'h7F800000, 32'h7F800000, 32'h7FC00000);
    step(1'b0, 1'b1, 32'h00400000, 32'h40000000, 32'h00000000);

    // Random stream; running drops for 5 cycles in the middle
    for (int i = 0; i < 100; i++)
      rstep((i >= 60 && i < 65) ? 1'b0 : 1'b1, rand_normal(i % 4 == 0), rand_normal(i % 4 == 0));

    // Mid-stream reset: in-flight work must vanish
    for (int i = 0; i < 10; i++)
      rstep(1'b1, rand_normal(1'b0), rand_normal(1'b0));
    step(1'b1, 1'b1, 32'h40C00000, 32'h40000000, 32'd0);
    for (int i = 0; i < LAT; i++)
      rstep(1'b1, 32'd0, 32'd0);
    step(1'b0, 1'b1, 32'h40C00000, 32'h40000000, 32'h40400000);
    step(1'b0, 1'b1, 32'h3F800000, 32'h40400000, 32'h3EAAAAAB);
    for (int i = 0; i < 10; i++)
      rstep(1'b1, rand_normal(1'b1), rand_normal(1'b0));

    repeat (LAT + 5) @(posedge clk);
    #3;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d results still pending, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
